// File: rtl/i2c_target_regs.sv
// i2c_target_regs: I2C target with two read-only status bytes and two read/write control bytes.
module i2c_target_regs #(
  parameter logic [6:0] ADDR = 7'h52,
  parameter int         FILT = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  input  logic [7:0] stat0,
  input  logic [7:0] stat1,
  output logic [7:0] ctrl0,
  output logic [7:0] ctrl1,
  output logic       wr_strobe,
  output logic       busy
);
  localparam int CW = $clog2(FILT + 1);
  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_ADDR  = 4'd1;
  localparam logic [3:0] S_AACK  = 4'd2;
  localparam logic [3:0] S_PTR   = 4'd3;
  localparam logic [3:0] S_PACK  = 4'd4;
  localparam logic [3:0] S_WDATA = 4'd5;
  localparam logic [3:0] S_WACK  = 4'd6;
  localparam logic [3:0] S_RDATA = 4'd7;
  localparam logic [3:0] S_RACK  = 4'd8;

  logic [1:0]    scl_s, sda_s;
  logic          scl_f, sda_f;
  logic [CW-1:0] scl_c, sda_c;
  logic          scl_chg, sda_chg, scl_rise, scl_fall, start, stop, shifting;
  logic [3:0]    state, bcnt;
  logic [7:0]    sr, rd_byte;
  logic [1:0]    ptr;
  logic          rw, oe;

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      scl_s <= 2'b11;
      sda_s <= 2'b11;
      scl_f <= 1'b1;
      sda_f <= 1'b1;
      scl_c <= '0;
      sda_c <= '0;
    end else begin
      scl_s <= {scl_s[0], scl_i};
      sda_s <= {sda_s[0], sda_i};
      scl_c <= (scl_s[1] == scl_f || scl_chg) ? '0 : scl_c + 1'b1;
      sda_c <= (sda_s[1] == sda_f || sda_chg) ? '0 : sda_c + 1'b1;
      if (scl_chg) scl_f <= scl_s[1];
      if (sda_chg) sda_f <= sda_s[1];
    end

  // Edges are taken from the filter's accept pulse so the FSM reacts in the same clk the level flips.
  assign scl_chg  = scl_s[1] != scl_f && scl_c == CW'(FILT - 1);
  assign sda_chg  = sda_s[1] != sda_f && sda_c == CW'(FILT - 1);
  assign scl_rise = scl_chg & ~scl_f;
  assign scl_fall = scl_chg & scl_f;
  assign start    = sda_chg & sda_f & scl_f & ~scl_chg;
  assign stop     = sda_chg & ~sda_f & scl_f & ~scl_chg;
  assign shifting = state == S_ADDR || state == S_PTR || state == S_WDATA;
  assign rd_byte  = ptr[1] ? (ptr[0] ? ctrl1 : ctrl0) : (ptr[0] ? stat1 : stat0);
  assign sda_oe   = oe & reset & ~start;

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state     <= S_IDLE;
      bcnt      <= 4'd0;
      sr        <= 8'h00;
      ptr       <= 2'd0;
      rw        <= 1'b0;
      oe        <= 1'b0;
      ctrl0     <= 8'h00;
      ctrl1     <= 8'h00;
      wr_strobe <= 1'b0;
      busy      <= 1'b0;
    end else begin
      wr_strobe <= 1'b0;
      if (start) begin
        state <= S_ADDR;
        bcnt  <= 4'd0;
        oe    <= 1'b0;
      end else if (stop) begin
        state <= S_IDLE;
        oe    <= 1'b0;
        busy  <= 1'b0;
      end else if (scl_rise) begin
        if (shifting) begin
          sr   <= {sr[6:0], sda_f};
          bcnt <= bcnt + 4'd1;
        end else if (state == S_RACK && sda_f) begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      end else if (scl_fall) begin
        case (state)
          S_ADDR:
            if (bcnt == 4'd8) begin
              if (sr[7:1] == ADDR) begin
                state <= S_AACK;
                oe    <= 1'b1;
                busy  <= 1'b1;
                rw    <= sr[0];
              end else begin
                state <= S_IDLE;
                busy  <= 1'b0;
              end
            end
          S_PTR:
            if (bcnt == 4'd8) begin
              ptr   <= sr[1:0];
              oe    <= 1'b1;
              state <= S_PACK;
            end
          S_WDATA:
            if (bcnt == 4'd8) begin
              if (ptr == 2'd2) ctrl0 <= sr;
              if (ptr == 2'd3) ctrl1 <= sr;
              wr_strobe <= ptr[1];
              ptr       <= ptr + 2'd1;
              oe        <= 1'b1;
              state     <= S_WACK;
            end
          S_AACK, S_PACK, S_WACK: begin
            bcnt <= 4'd0;
            if (state == S_AACK && rw) begin
              state <= S_RDATA;
              sr    <= rd_byte;
              oe    <= ~rd_byte[7];
            end else begin
              state <= state == S_AACK ? S_PTR : S_WDATA;
              oe    <= 1'b0;
            end
          end
          S_RDATA:
            if (bcnt == 4'd7) begin
              oe    <= 1'b0;
              ptr   <= ptr + 2'd1;
              state <= S_RACK;
            end else begin
              oe   <= ~sr[6];
              sr   <= {sr[6:0], 1'b0};
              bcnt <= bcnt + 4'd1;
            end
          S_RACK: begin
            state <= S_RDATA;
            bcnt  <= 4'd0;
            sr    <= rd_byte;
            oe    <= ~rd_byte[7];
          end
          default: ;
        endcase
      end
    end
endmodule
